div_scheduler: RTL and testbench

Round-robin scheduler that shares one programmable clock-divider datapath among `NUM_REQ` requesters. Each requester supplies its own divide value and an edge budget. The scheduler grants the divider to one requester at a time and runs it for the requested number of `clk_out` toggles. It then parks `clk_out` low and rotates priority. It sits between the PL clock domain consumers (blinkers, slow strobes, bit-bang engines) and a single divider counter.

---
 rtl/div_scheduler_pkg.sv | 31 +++
 rtl/div_scheduler_if.sv | 26 ++
 rtl/div_scheduler_core.sv | 46 ++++
 rtl/div_scheduler.sv | 100 ++++++++++
 tb/tb_div_scheduler.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_scheduler_pkg.sv
// Shared state encoding and round-robin pick helper for the divider scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    // First set bit at or after rr, wrapping within n requesters.
    // Scanning offsets high-to-low lets the smallest offset win last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   rr,
                                                 input int                 n);
        int               idx;
        logic [IDX_W-1:0] i4;
        rr_pick = '0;
        for (int off = MAX_REQ - 1; off >= 0; off--) begin
            if (off < n) begin
                idx = (int'(rr) + off) % n;
                i4  = IDX_W'(idx);
                if (req[i4]) rr_pick = i4;
            end
        end
    endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Requester-side bundle of the divider scheduler: requests in, grant and divided clock out.
interface div_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int DIV_WIDTH = 32,
    parameter int CNT_WIDTH = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DIV_WIDTH-1:0] div_value;
    logic [NUM_REQ*CNT_WIDTH-1:0] edge_count;
    logic [NUM_REQ-1:0]           grant;
    logic                         clk_out;
    logic                         tick;
    logic                         busy;
    logic                         done;
    logic                         abort;

    modport master (
        output req, div_value, edge_count,
        input  grant, clk_out, tick, busy, done, abort
    );

    modport slave (
        input  req, div_value, edge_count,
        output grant, clk_out, tick, busy, done, abort
    );
endinterface

// File: rtl/div_scheduler_core.sv
// Shared divider datapath: loadable wrap counter driving a toggle flop.
module div_core #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] d,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 wrap
);
    logic [DIV_WIDTH-1:0] d_q;
    logic [DIV_WIDTH-1:0] cnt;

    // Equality compare keeps D = all-ones legal without an overflow bit.
    assign wrap = run && (cnt == d_q);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            d_q     <= '0;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (load) begin
                d_q <= d;
                cnt <= '0;
            end else if (run) begin
                if (wrap) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/div_scheduler.sv
// Round-robin owner of one clock divider: grants a requester, runs its edge budget, parks low.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DIV_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input logic            clk_in,
    input logic            reset,
    div_scheduler_if.slave bus
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    logic [SEL_W-1:0]     sel;
    logic [SEL_W-1:0]     rr;
    logic [SEL_W-1:0]     sel_next;
    logic [CNT_WIDTH-1:0] e_left;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 done_q;
    logic                 abort_q;
    logic [IDX_W-1:0]     pick_idx;
    logic [DIV_WIDTH-1:0] d_sel;
    logic [CNT_WIDTH-1:0] e_sel;
    logic                 owner_req;
    logic                 drop;
    logic                 wrap;

    assign pick_idx  = rr_pick(MAX_REQ'(bus.req), IDX_W'(rr), NUM_REQ);
    assign d_sel     = bus.div_value[int'(sel)*DIV_WIDTH +: DIV_WIDTH];
    assign e_sel     = bus.edge_count[int'(sel)*CNT_WIDTH +: CNT_WIDTH];
    assign owner_req = bus.req[sel];
    assign sel_next  = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
    // An owner dropping req preempts everything, including a final toggle.
    assign drop      = ((state == LOAD) || (state == RUN)) && !owner_req;

    div_core #(.DIV_WIDTH(DIV_WIDTH)) u_core (
        .clk_in  (clk_in),
        .reset   (reset),
        .load    ((state == LOAD) && owner_req),
        .run     ((state == RUN) && owner_req),
        .clr     (drop || (state == DONE)),
        .d       (d_sel),
        .clk_out (bus.clk_out),
        .tick    (bus.tick),
        .wrap    (wrap)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            rr      <= '0;
            e_left  <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (drop) begin
                abort_q <= 1'b1;
                grant_q <= '0;
                rr      <= sel_next;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: if (|bus.req) begin
                        sel     <= SEL_W'(pick_idx);
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        state   <= LOAD;
                    end
                    LOAD: begin
                        e_left <= (e_sel == '0) ? CNT_WIDTH'(1) : e_sel;
                        state  <= RUN;
                    end
                    RUN: if (wrap) begin
                        e_left <= e_left - CNT_WIDTH'(1);
                        if (e_left == CNT_WIDTH'(1)) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        grant_q <= '0;
                        rr      <= sel_next;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.abort = abort_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench: stimulus predicts whole grant transactions, monitor checks every cycle of each.
module tb_div_scheduler;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clk_in = 1'b0;
    logic reset;

    div_scheduler_if #(.NUM_REQ(N), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    div_scheduler #(.NUM_REQ(N), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int owner;
        int d;
        int e;
        int ab;   // observation index of the abort pulse, -1 for normal completion
        bit b2b;  // granted right after the previous transaction's idle cycle
    } txn_t;

    txn_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   rr_m  = 0;
    int   dv[N];
    int   ev[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input int mask);
        for (int off = 0; off < N; off++)
            if (mask[(rr_m + off) % N]) return (rr_m + off) % N;
        return -1;
    endfunction

    function automatic int eeff(input int e);
        return (e == 0) ? 1 : e;
    endfunction

    // Observation index (cycles after the granting edge) of the last toggle.
    function automatic int last_n(input int d, input int e);
        return 2 + d + (e - 1) * (d + 1);
    endfunction

    task automatic apply_de();
        for (int i = 0; i < N; i++) begin
            bus.div_value[i*DW +: DW]  = DW'(dv[i]);
            bus.edge_count[i*CW +: CW] = CW'(ev[i]);
        end
    endtask

    task automatic push(input int o, input int ab, input bit b2b);
        txn_t t;
        t.owner = o; t.d = dv[o]; t.e = eeff(ev[o]); t.ab = ab; t.b2b = b2b;
        exp_q.push_back(t);
        rr_m = (o + 1) % N;
    endtask

    task automatic wait_dones(input int k, output bit ok);
        int seen = 0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_in);
            if (bus.done) begin
                seen++;
                if (seen == k) begin
                    ok = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic run_seq(input int mask, input int ng);
        bit ok;
        apply_de();
        for (int g = 0; g < ng; g++) push(pick(mask), -1, g > 0);
        bus.req = N'(mask);
        wait_dones(ng, ok);
        chk("seq_done_seen", ok, 1);
        bus.req = '0;
        repeat (3) @(negedge clk_in);
    endtask

    // Drop the owner's req m cycles into the grant; m < 0 drops it on the final toggle.
    task automatic run_abort(input int mask, input int m_sel);
        int o, l, m, rest;
        bit ok, seen;
        apply_de();
        o    = pick(mask);
        l    = last_n(dv[o], eeff(ev[o]));
        m    = (m_sel < 0) ? l - 1 : m_sel % l;
        push(o, m + 1, 0);
        rest = mask & ~(1 << o);
        if (rest != 0) push(pick(rest), -1, 1);
        bus.req = N'(mask);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_in);
            seen = (bus.grant != '0);
        end
        chk("abort_grant_seen", seen, 1);
        repeat (m) @(negedge clk_in);
        bus.req[o] = 1'b0;
        if (rest != 0) begin
            wait_dones(1, ok);
            chk("abort_next_done", ok, 1);
        end
        bus.req = '0;
        repeat (4) @(negedge clk_in);
    endtask

    // Monitor: pops a transaction when a grant appears and checks every output each cycle.
    bit   mon_active = 1'b0;
    int   mon_n;
    int   mon_cyc = 0;
    int   prev_end = -10;
    txn_t cur;

    initial begin
        forever begin
            @(negedge clk_in);
            mon_cyc++;
            if (reset) begin
                mon_active = 1'b0;
                continue;
            end
            if (!mon_active) begin
                if (bus.grant != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", bus.grant, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        mon_active = 1'b1;
                        mon_n = 0;
                        if (cur.b2b) chk("b2b_start_cycle", mon_cyc, prev_end + 1);
                    end
                end else begin
                    chk("idle_outputs", {bus.busy, bus.clk_out, bus.tick, bus.done, bus.abort}, 0);
                end
            end
            if (mon_active) begin
                int l, ne, ntog;
                logic [N-1:0] eg;
                bit eb, ec, et, ed, ea;
                l  = last_n(cur.d, cur.e);
                ne = (cur.ab >= 0) ? cur.ab : l + 1;
                if (mon_n == ne) begin
                    eg = '0; eb = 0; ec = 0; et = 0; ed = 0; ea = (cur.ab >= 0);
                end else begin
                    eg   = N'(1) << cur.owner;
                    eb   = 1;
                    ntog = (mon_n < 2 + cur.d) ? 0 : (mon_n - 2 - cur.d) / (cur.d + 1) + 1;
                    if (ntog > cur.e) ntog = cur.e;
                    ec   = ntog[0];
                    et   = (mon_n >= 2 + cur.d) && ((mon_n - 2 - cur.d) % (cur.d + 1) == 0);
                    ed   = (mon_n == l);
                    ea   = 0;
                end
                chk($sformatf("grant own=%0d n=%0d", cur.owner, mon_n), bus.grant, eg);
                chk($sformatf("busy n=%0d", mon_n), bus.busy, eb);
                chk($sformatf("clk_out d=%0d n=%0d", cur.d, mon_n), bus.clk_out, ec);
                chk($sformatf("tick d=%0d n=%0d", cur.d, mon_n), bus.tick, et);
                chk($sformatf("done e=%0d n=%0d", cur.e, mon_n), bus.done, ed);
                chk($sformatf("abort ab=%0d n=%0d", cur.ab, mon_n), bus.abort, ea);
                if (mon_n == ne) begin
                    mon_active = 1'b0;
                    prev_end = mon_cyc;
                end
                mon_n++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset          = 1'b1;
        bus.req        = '0;
        bus.div_value  = '0;
        bus.edge_count = '0;
        for (int i = 0; i < N; i++) begin dv[i] = 0; ev[i] = 0; end
        repeat (2) @(negedge clk_in);
        chk("reset_state", {bus.grant, bus.busy, bus.clk_out, bus.tick, bus.done, bus.abort}, 0);
        reset = 1'b0;
        @(negedge clk_in);

        dv[0] = 0; ev[0] = 4; run_seq(4'b0001, 1);
        dv[0] = 2; ev[0] = 3; run_seq(4'b0001, 1);
        for (int i = 0; i < N; i++) begin dv[i] = 1; ev[i] = 2; end
        run_seq(4'b1011, 4);
        dv[0] = 5; ev[0] = 10; dv[1] = 1; ev[1] = 1;
        run_abort(4'b0011, 10);
        dv[0] = 3; ev[0] = 0; run_seq(4'b0001, 1);
        run_abort(4'b0101, -1);
        run_abort(4'b0010, 0);

        for (int it = 0; it < 15; it++) begin
            int mask;
            mask = $urandom_range(1, 15);
            for (int i = 0; i < N; i++) begin
                dv[i] = $urandom_range(0, 3);
                ev[i] = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 2) == 0) run_abort(mask, $urandom_range(0, 30));
            else run_seq(mask, $urandom_range(1, 4));
        end

        // Asynchronous reset while the divided clock is high.
        dv[0] = 3; ev[0] = 10; apply_de();
        push(0, -1, 0);
        bus.req = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk_in);
            seen = bus.clk_out;
        end
        chk("clk_high_before_reset", seen, 1);
        #2 reset = 1'b1;
        #1 chk("reset_async", {bus.grant, bus.busy, bus.clk_out, bus.tick, bus.done, bus.abort}, 0);
        bus.req = '0;
        exp_q.delete();
        rr_m = 0;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        dv[2] = 1; ev[2] = 2;
        run_seq(4'b0100, 1);

        repeat (5) @(negedge clk_in);
        chk("queue_drained", exp_q.size(), 0);
        chk("monitor_idle", mon_active, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
